alt_vipvfr130_vfr_read_burst_scheduler: RTL and testbench
=========================================================

Name: alt_vipvfr130_vfr_read_burst_scheduler

Overview:
Sequences frame reads through the common Avalon-MM bursting master's user command port. A latched frame descriptor (base, words per line, line count, line stride) is split into read bursts of at most MAX_BURST words that never cross a line end. Commands are gated by a read-FIFO credit counter, so the master's read data FIFO cannot overflow and the user-side stall cannot deadlock. Sits between the frame reader control registers and the master instance.

Parameters:
ADDR_WIDTH, 32, byte address width; matches the master.
DATA_WIDTH, 32, master data width; BYTES_PER_WORD = DATA_WIDTH/8.
LEN_WIDTH, 11, width of burst_length on the master user port.
MAX_BURST, 32, maximum words per command; must be ≤ READ_FIFO_DEPTH and < 2^LEN_WIDTH.
READ_FIFO_DEPTH, 64, master read FIFO depth in words; sets credit limit.
LINE_WIDTH, 16, width of words-per-line and line-count fields.

Ports:
clock  in  1  single clock domain.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; descriptor sampled the same cycle; ignored while busy=1.
cfg_base_addr  in  ADDR_WIDTH  first-word byte address of frame.
cfg_words_per_line  in  LINE_WIDTH  words per line.
cfg_lines  in  LINE_WIDTH  line count.
cfg_line_stride  in  ADDR_WIDTH  byte offset between line starts.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse when all data for the frame has been consumed.
addr  out  ADDR_WIDTH  to master addr.
command  out  1  to master command.
is_burst  out  1  to master is_burst; constant 1.
is_write_not_read  out  1  to master; constant 0.
burst_length  out  LEN_WIDTH  to master burst_length.
stall  in  1  master stall.
word_consumed  in  1  downstream read accepted, i.e. read & !stall; one word left the FIFO.

Behaviour:
- Reset values: busy=0, done=0, command=0, addr=0, burst_length=0, outstanding=0, state=IDLE.
- Command acceptance: command=1 and stall=0 in the same cycle. While stall=1, command, addr and burst_length hold stable.
- len = min(words_left_in_line, MAX_BURST). It is computed combinationally from registered counters and registered onto burst_length together with command.
- outstanding, width clog2(READ_FIFO_DEPTH)+1:
  - next = outstanding + (accept ? len : 0) − (word_consumed ? 1 : 0).
  - Simultaneous accept and consume are both applied.
  - word_consumed while outstanding=0 is a protocol error and is ignored; the counter saturates at 0.
- Credit check: command asserts only if outstanding + len ≤ READ_FIFO_DEPTH.
- FSM states:
  - IDLE: on start, latch the descriptor and set busy=1. If words_per_line=0 or lines=0, go to DONE. Otherwise go to ISSUE with line_addr=base, cur_addr=base, words_left=words_per_line, lines_left=lines.
  - ISSUE: if the credit check fails, command=0 and the FSM stays. Otherwise command=1 is held until accepted. On accept:
    - cur_addr += len*BYTES_PER_WORD; words_left −= len.
    - If words_left reaches 0: lines_left −= 1. If lines_left reaches 0, go to DRAIN. Otherwise line_addr += stride, cur_addr = line_addr + stride, words_left = words_per_line.
    - The next command may assert the cycle after accept, giving back-to-back bursts when credit is available.
  - DRAIN: command=0. Wait for outstanding=0, including a consume in the same cycle, then go to DONE.
  - DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is permitted and unflagged.
- start during busy is ignored; no queueing.
- Reset asserted mid-frame clears all state immediately. Pending master commands are the master's concern.

Decomposition:
- Shared package alt_vipvfr130_vfr_pkg: FSM state enum (IDLE, ISSUE, DRAIN, DONE), descriptor struct, function for BYTES_PER_WORD, credit-width constant.
- One natural sub-module: alt_vipvfr130_vfr_credit_counter (outstanding counter with add-len/sub-one and credit compare). Everything else stays in the top.

Test Plan:
- words=100, lines=1, base=0x1000, MAX_BURST=32, stall=0, consumer always ready → bursts of 32, 32, 32, 4 at 0x1000, 0x1080, 0x1100, 0x1180; done after the 100th consume.
- words=40, lines=3, stride=0x400, base=0 → per line (32, 8) at 0x0/0x80, 0x400/0x480, 0x800/0x880; 6 commands total; busy high throughout.
- Consumer idle, words=200, FIFO depth 64 → exactly two 32-word commands issued, then command=0. A single word_consumed does not release a third; after 32 consumes the third issues.
- stall held high for 5 cycles with command=1 → addr and burst_length unchanged; exactly one acceptance recorded when stall drops.
- cfg_lines=0 with start → busy 1 cycle, done pulse, zero commands. start pulsed while busy → ignored, frame completes unchanged.
- Reset driven low mid-ISSUE with outstanding=20 → all outputs at reset values asynchronously. A subsequent start runs a full frame correctly.

Source files
------------

// File: rtl/alt_vipvfr130_vfr_pkg.sv
// Shared types and helpers for the VFR read burst scheduler: FSM states,
// the frame descriptor and the width/size helpers used by top and counter.
package alt_vipvfr130_vfr_pkg;

    localparam int VFR_ADDR_W = 32;
    localparam int VFR_LINE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vfr_state_e;

    typedef struct packed {
        logic [VFR_ADDR_W-1:0] base_addr;
        logic [VFR_LINE_W-1:0] words_per_line;
        logic [VFR_LINE_W-1:0] lines;
        logic [VFR_ADDR_W-1:0] line_stride;
    } vfr_desc_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // One extra bit so a completely full FIFO (outstanding == depth) is representable.
    function automatic int credit_w(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

endpackage

// File: rtl/alt_vipvfr130_vfr_credit_counter.sv
// Tracks words requested from the master but not yet consumed downstream,
// and answers whether a candidate burst still fits in the read FIFO.
module alt_vipvfr130_vfr_credit_counter
    import alt_vipvfr130_vfr_pkg::*;
#(
    parameter int LEN_WIDTH       = 11,
    parameter int READ_FIFO_DEPTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 accept,
    input  logic [LEN_WIDTH-1:0] accept_len,
    input  logic                 consume,
    input  logic [LEN_WIDTH-1:0] req_len,
    output logic                 credit_ok,
    output logic                 drained_next
);

    localparam int CW = credit_w(READ_FIFO_DEPTH);
    localparam int NW = CW + LEN_WIDTH;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_next;
    logic [NW-1:0] need;

    // Credit is judged against the value the counter will hold when the
    // candidate command becomes visible, so back-to-back bursts stay safe.
    always_comb begin
        out_next = outstanding;
        if (accept)
            out_next = out_next + CW'(accept_len);
        if (consume && (outstanding != '0))
            out_next = out_next - CW'(1);
        need         = NW'(out_next) + NW'(req_len);
        credit_ok    = (need <= NW'(READ_FIFO_DEPTH));
        drained_next = (out_next == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            outstanding <= '0;
        else
            outstanding <= out_next;
    end

endmodule

// File: rtl/alt_vipvfr130_vfr_read_burst_scheduler.sv
// Splits a latched frame descriptor into line-bounded read bursts for the
// Avalon-MM bursting master, gated by read-FIFO credit.
module alt_vipvfr130_vfr_read_burst_scheduler
    import alt_vipvfr130_vfr_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 11,
    parameter int MAX_BURST       = 32,
    parameter int READ_FIFO_DEPTH = 64,
    parameter int LINE_WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [LINE_WIDTH-1:0] cfg_words_per_line,
    input  logic [LINE_WIDTH-1:0] cfg_lines,
    input  logic [ADDR_WIDTH-1:0] cfg_line_stride,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  command,
    output logic                  is_burst,
    output logic                  is_write_not_read,
    output logic [LEN_WIDTH-1:0]  burst_length,
    input  logic                  stall,
    input  logic                  word_consumed
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);

    vfr_state_e            state, state_nxt;
    vfr_desc_t             cfg;
    logic [LINE_WIDTH-1:0] wpl_q, words_left, lines_left;
    logic [LINE_WIDTH-1:0] words_left_post, lines_left_post;
    logic [ADDR_WIDTH-1:0] stride_q, line_addr, cur_addr;
    logic [ADDR_WIDTH-1:0] line_addr_post, cur_addr_post;
    logic [LEN_WIDTH-1:0]  len_post;
    logic                  accept, frame_end, credit_ok, drained_next;
    logic                  cmd_nxt, load;

    // Descriptor is carried at package widths; top parameters default to them.
    assign cfg = '{
        base_addr:      VFR_ADDR_W'(cfg_base_addr),
        words_per_line: VFR_LINE_W'(cfg_words_per_line),
        lines:          VFR_LINE_W'(cfg_lines),
        line_stride:    VFR_ADDR_W'(cfg_line_stride)
    };

    assign accept            = command & ~stall;
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign is_burst          = 1'b1;
    assign is_write_not_read = 1'b0;

    // Position after the burst currently on the bus (if accepted this cycle);
    // the next burst length is derived from it so bursts can go back to back.
    always_comb begin
        words_left_post = words_left;
        lines_left_post = lines_left;
        cur_addr_post   = cur_addr;
        line_addr_post  = line_addr;
        frame_end       = 1'b0;
        if (accept) begin
            words_left_post = words_left - LINE_WIDTH'(burst_length);
            cur_addr_post   = cur_addr + ADDR_WIDTH'(burst_length) * ADDR_WIDTH'(BPW);
            if (words_left_post == '0) begin
                lines_left_post = lines_left - LINE_WIDTH'(1);
                if (lines_left_post == '0) begin
                    frame_end = 1'b1;
                end else begin
                    line_addr_post  = line_addr + stride_q;
                    cur_addr_post   = line_addr + stride_q;
                    words_left_post = wpl_q;
                end
            end
        end
        if (words_left_post > LINE_WIDTH'(MAX_BURST))
            len_post = LEN_WIDTH'(MAX_BURST);
        else
            len_post = LEN_WIDTH'(words_left_post);
    end

    alt_vipvfr130_vfr_credit_counter #(
        .LEN_WIDTH       (LEN_WIDTH),
        .READ_FIFO_DEPTH (READ_FIFO_DEPTH)
    ) u_credit (
        .clock        (clock),
        .reset        (reset),
        .accept       (accept),
        .accept_len   (burst_length),
        .consume      (word_consumed),
        .req_len      (len_post),
        .credit_ok    (credit_ok),
        .drained_next (drained_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if ((cfg.words_per_line == '0) || (cfg.lines == '0))
                        state_nxt = DONE;
                    else
                        state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (frame_end)
                    state_nxt = DRAIN;
                else if (command && stall)
                    cmd_nxt = 1'b1;
                else
                    cmd_nxt = credit_ok;
            end
            DRAIN: begin
                if (drained_next)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            command      <= 1'b0;
            addr         <= '0;
            burst_length <= '0;
            wpl_q        <= '0;
            stride_q     <= '0;
            line_addr    <= '0;
            cur_addr     <= '0;
            words_left   <= '0;
            lines_left   <= '0;
        end else begin
            command <= cmd_nxt;
            // While stalled the post values equal the held ones, so this is stable.
            if (cmd_nxt) begin
                addr         <= cur_addr_post;
                burst_length <= len_post;
            end
            if (load) begin
                wpl_q      <= LINE_WIDTH'(cfg.words_per_line);
                stride_q   <= ADDR_WIDTH'(cfg.line_stride);
                line_addr  <= ADDR_WIDTH'(cfg.base_addr);
                cur_addr   <= ADDR_WIDTH'(cfg.base_addr);
                words_left <= LINE_WIDTH'(cfg.words_per_line);
                lines_left <= LINE_WIDTH'(cfg.lines);
            end else begin
                line_addr  <= line_addr_post;
                cur_addr   <= cur_addr_post;
                words_left <= words_left_post;
                lines_left <= lines_left_post;
            end
        end
    end

endmodule

// File: tb/tb_alt_vipvfr130_vfr_read_burst_scheduler.sv
// Randomized bench: expected burst lists are derived from the descriptor,
// FIFO occupancy is tracked from observed accepts/consumes.
module tb_alt_vipvfr130_vfr_read_burst_scheduler;

    localparam int AW = 32, LW = 16, LENW = 11, MAXB = 32, DEPTH = 64, BPW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   cfg_base_addr = '0, cfg_line_stride = '0;
    logic [LW-1:0]   cfg_words_per_line = '0, cfg_lines = '0;
    logic            busy, done, command, is_burst, is_write_not_read;
    logic [AW-1:0]   addr;
    logic [LENW-1:0] burst_length;
    logic            stall = 1'b0, word_consumed = 1'b0;

    always #5 clock = ~clock;

    alt_vipvfr130_vfr_read_burst_scheduler dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_words_per_line (cfg_words_per_line),
        .cfg_lines          (cfg_lines),
        .cfg_line_stride    (cfg_line_stride),
        .busy               (busy),
        .done               (done),
        .addr               (addr),
        .command            (command),
        .is_burst           (is_burst),
        .is_write_not_read  (is_write_not_read),
        .burst_length       (burst_length),
        .stall              (stall),
        .word_consumed      (word_consumed)
    );

    int            n_checks = 0, n_fail = 0;
    logic [AW-1:0] exp_addr[$];
    int            exp_len[$];
    logic [AW-1:0] obs_addr[$];
    int            obs_len[$];
    int            fifo_cnt = 0, done_seen = 0;
    logic          hold_prev = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [LENW-1:0] prev_len = '0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model queue / FIFO occupancy.
    always @(negedge clock) begin
        if (reset) begin
            chk("is_burst", is_burst, 1);
            chk("is_write_not_read", is_write_not_read, 0);
            if (hold_prev) begin
                chk("stall_hold_cmd", command, 1);
                chk("stall_hold_addr", addr, prev_addr);
                chk("stall_hold_len", burst_length, prev_len);
            end
            if (command) begin
                chk("credit_limit", (fifo_cnt + int'(burst_length)) <= DEPTH, 1);
                chk("busy_with_cmd", busy, 1);
            end
            if (command && !stall) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    chk("cmd_addr", addr, exp_addr.pop_front());
                    chk("cmd_len", burst_length, exp_len.pop_front());
                end
                obs_addr.push_back(addr);
                obs_len.push_back(int'(burst_length));
            end
            if (done) begin
                chk("done_single_pulse", prev_done, 0);
                chk("done_drained", fifo_cnt, 0);
                chk("done_all_cmds", exp_addr.size(), 0);
                chk("done_busy", busy, 1);
                done_seen++;
            end
            if (fifo_cnt > 0)
                chk("busy_pending", busy, 1);
            hold_prev = command && stall;
            prev_addr = addr;
            prev_len  = burst_length;
            prev_done = done;
            if (word_consumed && fifo_cnt > 0) fifo_cnt--;
            if (command && !stall) fifo_cnt += int'(burst_length);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic build(input logic [AW-1:0] base, input int wpl, input int lines,
                         input logic [AW-1:0] stride);
        for (int l = 0; l < lines; l++)
            for (int w = 0; w < wpl; w += MAXB) begin
                logic [AW-1:0] a;
                a = base + AW'(l) * stride + AW'(w * BPW);
                exp_addr.push_back(a);
                exp_len.push_back((wpl - w) < MAXB ? (wpl - w) : MAXB);
            end
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input int wpl, input int lines,
                               input logic [AW-1:0] stride);
        build(base, wpl, lines, stride);
        obs_addr.delete();
        obs_len.delete();
        cfg_base_addr      = base;
        cfg_words_per_line = LW'(wpl);
        cfg_lines          = LW'(lines);
        cfg_line_stride    = stride;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Descriptor must have been latched; scramble the inputs.
        cfg_base_addr      = $urandom;
        cfg_words_per_line = LW'($urandom_range(1, 50));
        cfg_lines          = LW'($urandom_range(1, 5));
        cfg_line_stride    = $urandom;
    endtask

    task automatic wait_done(input int d0, input int stall_pct, input int cons_pct,
                             input int restart_at);
        int n = 0;
        while (done_seen == d0 && n < 20000) begin
            stall         = ($urandom_range(0, 99) < stall_pct);
            word_consumed = (fifo_cnt > 0) && ($urandom_range(0, 99) < cons_pct);
            start         = (n == restart_at);
            tick();
            n++;
        end
        stall = 1'b0;
        word_consumed = 1'b0;
        start = 1'b0;
        chk("frame_done", done_seen - d0, 1);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int wpl, input int lines,
                             input logic [AW-1:0] stride, input int stall_pct,
                             input int cons_pct, input int restart_at);
        int d0, nexp;
        d0 = done_seen;
        nexp = exp_addr.size();
        start_frame(base, wpl, lines, stride);
        nexp = exp_addr.size() - nexp;
        wait_done(d0, stall_pct, cons_pct, restart_at);
        chk("n_cmds", obs_addr.size(), nexp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_command", command, 0);
        chk("rst_addr", addr, 0);
        chk("rst_len", burst_length, 0);
        tick();
        reset = 1'b1;
        tick();

        // Stray consume while idle must not disturb the credit counter
        word_consumed = 1'b1;
        tick();
        word_consumed = 1'b0;
        tick();

        // 100 words, single line
        run_frame(32'h1000, 100, 1, 32'h0, 0, 100, -1);
        chk("t1_len0", obs_len[0], 32);
        chk("t1_len3", obs_len[3], 4);
        chk("t1_addr1", obs_addr[1], 32'h1080);
        chk("t1_addr3", obs_addr[3], 32'h1180);

        // 40 words x 3 lines, stride 0x400, with ignored restart mid-frame
        run_frame(32'h0, 40, 3, 32'h400, 0, 100, 5);
        chk("t2_addr2", obs_addr[2], 32'h400);
        chk("t2_len3", obs_len[3], 8);
        chk("t2_addr5", obs_addr[5], 32'h880);

        // Credit gating with an idle consumer
        d0 = done_seen;
        start_frame(32'h2000, 200, 1, 32'h0);
        repeat (30) tick();
        chk("credit_two_cmds", obs_addr.size(), 2);
        chk("credit_cmd_low", command, 0);
        word_consumed = 1'b1;
        tick();
        word_consumed = 1'b0;
        repeat (10) tick();
        chk("credit_one_consume", obs_addr.size(), 2);
        repeat (31) begin word_consumed = 1'b1; tick(); end
        word_consumed = 1'b0;
        repeat (5) tick();
        chk("credit_third", obs_addr.size(), 3);
        wait_done(d0, 0, 100, -1);

        // Stall held with a pending command
        d0 = done_seen;
        stall = 1'b1;
        start_frame(32'h3000, 40, 1, 32'h0);
        n = 0;
        while (!command && n < 20) begin tick(); n++; end
        chk("stall_cmd_up", command, 1);
        repeat (5) tick();
        chk("stall_no_accept", obs_addr.size(), 0);
        chk("stall_addr", addr, 32'h3000);
        chk("stall_len", burst_length, 32);
        stall = 1'b0;
        @(posedge clock);
        #3;
        chk("stall_one_accept", obs_addr.size(), 1);
        wait_done(d0, 0, 100, -1);

        // Empty frames
        for (int k = 0; k < 2; k++) begin
            d0 = done_seen;
            obs_addr.delete();
            cfg_words_per_line = (k == 0) ? LW'(10) : LW'(0);
            cfg_lines          = (k == 0) ? LW'(0) : LW'(3);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("empty_busy", busy, 1);
            chk("empty_done", done, 1);
            tick();
            chk("empty_busy_clr", busy, 0);
            chk("empty_done_pulse", done_seen - d0, 1);
            chk("empty_no_cmds", obs_addr.size(), 0);
        end

        // Randomized frames, including an address-wrap case
        for (int k = 0; k < 6; k++) begin
            logic [AW-1:0] b, s;
            b = (k == 0) ? 32'hFFFF_FFC0 : $urandom;
            s = $urandom;
            run_frame(b, $urandom_range(1, 90), $urandom_range(1, 4), s,
                      $urandom_range(0, 40), $urandom_range(30, 100), -1);
        end

        // Asynchronous reset mid-ISSUE with 20 words outstanding
        start_frame(32'h5000, 20, 5, 32'h100);
        n = 0;
        while (obs_addr.size() < 1 && n < 20) begin tick(); n++; end
        stall = 1'b1;
        tick();
        chk("mid_outstanding", fifo_cnt, 20);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_command", command, 0);
        chk("arst_addr", addr, 0);
        chk("arst_len", burst_length, 0);
        stall = 1'b0;
        exp_addr.delete();
        exp_len.delete();
        fifo_cnt = 0;
        hold_prev = 1'b0;
        prev_done = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Counter must restart from zero: two full bursts fit again
        d0 = done_seen;
        start_frame(32'h6000, 200, 1, 32'h0);
        repeat (30) tick();
        chk("post_rst_two_cmds", obs_addr.size(), 2);
        wait_done(d0, 10, 80, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
